// File: rtl/adder_1b_if.sv
// Bundle of the full adder's operand, control and result signals.
// The master side (test driver or surrounding datapath) drives the operand
// bits and registered-path controls; the slave side (the adder) returns the
// combinational sum/carry and the registered serial state.
interface adder_1b_if #(
  parameter int COUNT_W = 8
);

  logic               a;
  logic               b;
  logic               c_in;
  logic               en;
  logic               serial;
  logic               clr_carry;

  logic               sum;
  logic               c_out;
  logic               sum_q;
  logic               carry_q;
  logic [COUNT_W-1:0] ops_count;

  modport master (
    output a,
    output b,
    output c_in,
    output en,
    output serial,
    output clr_carry,
    input  sum,
    input  c_out,
    input  sum_q,
    input  carry_q,
    input  ops_count
  );

  modport slave (
    input  a,
    input  b,
    input  c_in,
    input  en,
    input  serial,
    input  clr_carry,
    output sum,
    output c_out,
    output sum_q,
    output carry_q,
    output ops_count
  );

endinterface

// File: rtl/adder_1b.sv
// 1-bit full adder with two faces:
//  - a purely combinational sum/carry leaf, usable as a ripple-carry cell;
//  - a registered bit-serial adder that consumes multi-bit operands LSB-first,
//    one bit per enabled clock, feeding its own carry back between bits.
// A saturating counter records how many enabled add cycles have happened.
module adder_1b #(
  parameter int COUNT_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  adder_1b_if.slave   add_io
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  logic               sum_q;
  logic               sum_d;
  logic               carry_q;
  logic               carry_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic               cin_eff;

  // Combinational leaf: independent of clock, reset and the registered controls.
  always_comb begin
    add_io.sum   = add_io.a ^ add_io.b ^ add_io.c_in;
    add_io.c_out = (add_io.a & add_io.b) |
                   (add_io.a & add_io.c_in) |
                   (add_io.b & add_io.c_in);
  end

  // Next state of the registered path: carry clear wins over an enabled add, otherwise hold.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    count_d = count_q;
    cin_eff = add_io.serial ? carry_q : add_io.c_in;

    if (add_io.clr_carry) begin
      carry_d = 1'b0;
    end else if (add_io.en) begin
      sum_d   = add_io.a ^ add_io.b ^ cin_eff;
      carry_d = (add_io.a & add_io.b) |
                (add_io.a & cin_eff) |
                (add_io.b & cin_eff);
      if (count_q != COUNT_MAX) begin
        count_d = count_q + COUNT_ONE;
      end
    end
  end

  // Registered state; reset clears everything immediately, independent of the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      count_q <= count_d;
    end
  end

  assign add_io.sum_q     = sum_q;
  assign add_io.carry_q   = carry_q;
  assign add_io.ops_count = count_q;

endmodule

// File: tb/tb_adder_1b.sv
// Bench for adder_1b: every registered-path cycle pushes the expected state
// into a queue that a separate monitor pops and compares after each clock
// edge; the combinational leaf and serial word results are checked against
// plain integer arithmetic.
module tb_adder_1b;

  typedef struct packed {
    logic        s;
    logic        c;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;

  adder_1b_if #(.COUNT_W(8)) bus ();
  adder_1b_if #(.COUNT_W(2)) bus2 ();

  adder_1b #(.COUNT_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .add_io (bus)
  );

  adder_1b #(.COUNT_W(2)) dutSat (
    .clk    (clk),
    .rst_n  (rst_n),
    .add_io (bus2)
  );

  int   checks = 0;
  int   fails  = 0;
  exp_t expQ[$];

  bit   mSum;
  bit   mCarry;
  int   mCount;

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard bound on run time so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one registered-path cycle, predict its result and check the combinational leaf.
  task automatic applyStimulus(input bit a, input bit b, input bit cin,
                               input bit en, input bit serial, input bit clr);
    bit   cinEff;
    int   total;
    exp_t e;
    @(negedge clk);
    bus.a         = a;
    bus.b         = b;
    bus.c_in      = cin;
    bus.en        = en;
    bus.serial    = serial;
    bus.clr_carry = clr;
    cinEff = serial ? mCarry : cin;
    total  = int'(a) + int'(b) + int'(cinEff);
    if (clr) begin
      mCarry = 1'b0;
    end else if (en) begin
      mSum   = bit'(total % 2);
      mCarry = bit'(total / 2);
      if (mCount < 255) mCount++;
    end
    e.s   = mSum;
    e.c   = mCarry;
    e.cnt = mCount;
    expQ.push_back(e);
    #1;
    total = int'(a) + int'(b) + int'(cin);
    checkOutput("comb sum", 32'(bus.sum), total % 2);
    checkOutput("comb c_out", 32'(bus.c_out), total / 2);
  endtask

  // Add two w-bit words serially and compare the collected bits with integer addition.
  task automatic serialWord(input int w, input int opA, input int opB);
    int got;
    applyStimulus(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b1, 1'b1);
    @(posedge clk);
    #2;
    got = 0;
    for (int i = 0; i < w; i++) begin
      applyStimulus(bit'((opA >> i) & 1), bit'((opB >> i) & 1),
                    bit'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      got = got | (int'(bus.sum_q) << i);
    end
    got = got | (int'(bus.carry_q) << w);
    checkOutput("serial word result", got, opA + opB);
  endtask

  // Scoreboard monitor: after each rising edge, compare the registered outputs with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("sum_q", 32'(bus.sum_q), 32'(e.s));
        checkOutput("carry_q", 32'(bus.carry_q), 32'(e.c));
        checkOutput("ops_count", 32'(bus.ops_count), e.cnt);
      end
    end
  end

  // Main sequence of directed and random stimulus.
  initial begin
    int total;
    rst_n = 1'b0;
    bus.a = 1'b0; bus.b = 1'b0; bus.c_in = 1'b0;
    bus.en = 1'b0; bus.serial = 1'b0; bus.clr_carry = 1'b0;
    bus2.a = 1'b0; bus2.b = 1'b0; bus2.c_in = 1'b0;
    bus2.en = 1'b0; bus2.serial = 1'b0; bus2.clr_carry = 1'b0;
    mSum = 1'b0; mCarry = 1'b0; mCount = 0;

    // Exhaustive truth table while still in reset.
    #7;
    for (int v = 0; v < 8; v++) begin
      bus.a    = v[2];
      bus.b    = v[1];
      bus.c_in = v[0];
      #1;
      total = v[2] + v[1] + v[0];
      checkOutput("truth table sum", 32'(bus.sum), total % 2);
      checkOutput("truth table c_out", 32'(bus.c_out), total / 2);
    end
    bus.a = 1'b0; bus.b = 1'b0; bus.c_in = 1'b0;
    checkOutput("reset sum_q", 32'(bus.sum_q), 0);
    checkOutput("reset carry_q", 32'(bus.carry_q), 0);
    checkOutput("reset ops_count", 32'(bus.ops_count), 0);

    @(negedge clk);
    rst_n = 1'b1;

    // Non-serial registered add: 1 + 0 + 1.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("nonserial sum_q", 32'(bus.sum_q), 0);
    checkOutput("nonserial carry_q", 32'(bus.carry_q), 1);
    checkOutput("nonserial ops_count", 32'(bus.ops_count), 1);

    // Serial 3 + 3 = 6.
    serialWord(3, 3, 3);
    checkOutput("3+3 carry_q", 32'(bus.carry_q), 0);
    checkOutput("3+3 ops_count", 32'(bus.ops_count), 4);

    // Priority and hold.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    checkOutput("clr priority carry_q", 32'(bus.carry_q), 0);
    checkOutput("clr priority sum_q", 32'(bus.sum_q), 0);
    checkOutput("clr priority ops_count", 32'(bus.ops_count), 5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("hold sum_q", 32'(bus.sum_q), 0);
    checkOutput("hold ops_count", 32'(bus.ops_count), 5);

    // Saturation on the 2-bit counter instance while the main adder holds.
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      bus2.en = 1'b1;
      @(posedge clk);
      #2;
      checkOutput("sat ops_count", 32'(bus2.ops_count), (k < 3) ? k : 3);
    end
    bus2.en = 1'b0;

    // Random mix of single cycles and serial words.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        int w;
        w = $urandom_range(1, 8);
        serialWord(w, $urandom_range(0, (1 << w) - 1), $urandom_range(0, (1 << w) - 1));
      end else begin
        applyStimulus(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                      bit'($urandom_range(0, 1)), ($urandom_range(0, 9) < 8),
                      bit'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
      end
    end
    checkOutput("count saturated at 255", 32'(bus.ops_count), 255);

    // Asynchronous reset mid-clock after loading ones into both state bits.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    bus.a    = 1'b1;
    bus.b    = 1'b0;
    bus.c_in = 1'b1;
    #1;
    checkOutput("async reset sum_q", 32'(bus.sum_q), 0);
    checkOutput("async reset carry_q", 32'(bus.carry_q), 0);
    checkOutput("async reset ops_count", 32'(bus.ops_count), 0);
    checkOutput("comb in reset sum", 32'(bus.sum), 0);
    checkOutput("comb in reset c_out", 32'(bus.c_out), 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("reset held sum_q", 32'(bus.sum_q), 0);
    checkOutput("reset held ops_count", 32'(bus.ops_count), 0);
    bus.en = 1'b0;
    bus.clr_carry = 1'b0;
    mSum = 1'b0; mCarry = 1'b0; mCount = 0;
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("post reset ops_count", 32'(bus.ops_count), 1);
    checkOutput("post reset sum_q", 32'(bus.sum_q), 1);

    if (expQ.size() != 0) begin
      checkOutput("scoreboard drained", expQ.size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
